time_display: RTL and testbench
===============================

# time_display

Consumer end of the countdown interface: takes the 6-bit binary `time_remain` from the game countdown timer and drives a two-digit multiplexed common-anode seven-segment display. A sequential binary-to-BCD converter re-runs whenever the input value changes. A registered `time_up` flag goes to the game FSM. The block sits between the countdown timer and the board display pins.

## Interface
- `SCAN_DIV`, 50000: clocks per digit slot (1 kHz digit switch at 50 MHz).
- `BLINK_DIV`, 12500000: clocks per blink phase (2 Hz blink).
- `LOW_THRESH`, 10: blink when 0 < value ≤ LOW_THRESH.
- `clk50M`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `time_remain`  in  6  seconds remaining, binary, 0..63.
- `seg`  out  8  segments, active-low; [6:0]=gfedcba, [7]=dp (always 1).
- `sel`  out  2  digit enables, active-low; [0]=ones, [1]=tens.
- `time_up`  out  1  high while last converted value == 0.

## Operation
- Input `time_remain` registered every clock into `in_r`.
- Converter FSM:
  - IDLE: if `in_r != last_conv`, load shift reg, `last_conv <= in_r`, go to SHIFT.
  - SHIFT: 6 iterations of double-dabble (add 3 to any BCD nibble ≥5, then shift left 1).
  - DONE: latch `tens`/`ones`, update `time_up`, return to IDLE.
- Input change during SHIFT/DONE: ignored until IDLE, then caught by the `last_conv` compare. The final displayed value always equals the settled input.
- Values 60..63 display as-is (no clamp). `tens` is 0..6.
- Scan counter runs 0..SCAN_DIV-1. At the terminal count, `digit` toggles.
  - `digit`=0: `sel`=2'b10, ones shown.
  - `digit`=1: `sel`=2'b01, tens shown.
- Leading-zero blanking: tens digit shows `seg`=8'hFF when `tens`==0. `sel` is still driven.
- Encoding for 0..9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex).
- `time_up`=1 when converted value is 0. Display then shows steady "0" (tens blank).

## Timing
- Reset values:
  - `seg`=8'hFF, `sel`=2'b11, `time_up`=0.
  - `tens`=`ones`=0, `last_conv`=0, `in_r`=0.
  - FSM=IDLE, scan/blink counters=0, `digit`=0, blink phase=0.
- After reset `sel` stays 2'b11 until the first scan terminal count.
- Latency from input change (edge N) to `tens`/`ones`/`time_up` updated: 9 clocks.
  - 1 clock: input register.
  - 1 clock: IDLE compare/load.
  - 6 clocks: SHIFT.
  - 1 clock: DONE.
- `seg`/`sel` are registered. They update 1 clock after the scan terminal count or after the BCD latch.
- Reset mid-conversion aborts to IDLE. A pending value is reconverted after release because `last_conv`=0.

## Configuration
- `LOW_TIME_BLINK_EN` defined: a blink counter toggles the phase every BLINK_DIV clocks.
  - When 0 < value ≤ LOW_THRESH and phase=1, both digits show `seg`=8'hFF.
  - Phase counter runs freely and is not reset on value change.
- Undefined: no blink counter or phase logic; display is always steady.

## Structure
- Package `time_display_pkg`:
  - segment code constants SEG_0..SEG_9 and SEG_BLANK.
  - converter state encoding IDLE/SHIFT/DONE.
  - sel constants SEL_ONES, SEL_TENS, SEL_OFF.
- One sub-module, `bin2bcd_seq`: converter FSM with a start/busy/done handshake.
  - `start` is accepted only when not busy.
  - `done` is a 1-clock pulse carrying `tens`/`ones`.
- Top level holds the input register, compare, scan, blink and output mux.

## Test plan
Bench uses SCAN_DIV=4, BLINK_DIV=16.
- Reset, then input held at 60.
  - `seg`=FF, `sel`=11 during reset.
  - 9 clocks after release: `tens`=6, `ones`=0.
  - Scan alternates `sel`=10/`seg`=C0 and `sel`=01/`seg`=82.
- Input 60→59 step → after 9 clocks, ones digit shows 90 and tens digit shows 92.
- Input 7 → tens slot `seg`=FF, ones slot `seg`=F8.
  - With LOW_TIME_BLINK_EN: both slots go FF every other 16-clock phase.
- Input 0 → `time_up`=1 within 9 clocks; ones shows C0 steadily with no blink.
  - Input 5 afterwards → `time_up` returns to 0.
- Input changed 45→44→43 on consecutive clocks mid-conversion → final display 43, no stuck value.
- `rst_n` asserted during SHIFT → outputs return to reset values immediately (async).
  - After release, the current input is reconverted within 9 clocks.

Source files
------------

// File: rtl/time_display_pkg.sv
// Shared types and constants for the time_display block.
// Segment codes are active-low gfedcba with dp in bit 7.
package time_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] SEL_ONES = 2'b10;
  localparam logic [1:0] SEL_TENS = 2'b01;
  localparam logic [1:0] SEL_OFF  = 2'b11;

  function automatic logic [7:0] seg_of(
    input logic [3:0] d
  );
    logic [7:0] s;
    unique case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One double-dabble iteration on {tens, ones, bin[5:0]}.
  function automatic logic [13:0] dd_step(
    input logic [13:0] s
  );
    logic [13:0] t;
    t = s;
    if (t[9:6] >= 4'd5)
      t[9:6] = t[9:6] + 4'd3;
    if (t[13:10] >= 4'd5)
      t[13:10] = t[13:10] + 4'd3;
    return t << 1;
  endfunction

endpackage

// File: rtl/time_display_if.sv
// Countdown-to-display bundle: binary seconds in,
// multiplexed segment pins and time_up flag out.
interface time_display_if;
  logic [5:0] time_remain;
  logic [7:0] seg;
  logic [1:0] sel;
  logic       time_up;

  modport master (
    output time_remain,
    input  seg,
    input  sel,
    input  time_up
  );

  modport slave (
    input  time_remain,
    output seg,
    output sel,
    output time_up
  );
endinterface

// File: rtl/time_display_bin2bcd_seq.sv
// Sequential 6-bit binary to two-digit BCD converter.
// start is taken only in IDLE; done pulses for one clock.
module bin2bcd_seq
  import time_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  conv_state_t state, state_nx;
  logic [13:0] sr, sr_nx;
  logic [2:0]  cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sr    <= sr_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          sr_nx    = {8'd0, bin};
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        sr_nx = dd_step(sr);
        if (cnt == 3'd5)
          state_nx = DONE;
        else
          cnt_nx = cnt + 3'd1;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign tens = sr[13:10];
  assign ones = sr[9:6];

endmodule

// File: rtl/time_display.sv
// Two-digit multiplexed seven-segment driver for the countdown.
// Optional low-time blink is built with LOW_TIME_BLINK_EN.
module time_display
  import time_display_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 12500000,
  parameter int LOW_THRESH = 10
) (
  input logic           clk50M,
  input logic           rst_n,
  time_display_if.slave bus
);

  localparam int SW = $clog2(SCAN_DIV);

  logic [5:0]    in_r, last_conv;
  logic          start, busy, done;
  logic [3:0]    tens_c, ones_c;
  logic [3:0]    tens, ones;
  logic          time_up;
  logic [SW-1:0] scan_cnt;
  logic          scan_tc, digit, scan_on;
  logic          blank;
  logic [7:0]    seg_r, seg_nx;
  logic [1:0]    sel_r, sel_nx;

  assign start = (in_r != last_conv);

  bin2bcd_seq u_conv (
    .clk   (clk50M),
    .rst_n (rst_n),
    .start (start),
    .bin   (in_r),
    .busy  (busy),
    .done  (done),
    .tens  (tens_c),
    .ones  (ones_c)
  );

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      in_r      <= '0;
      last_conv <= '0;
      tens      <= '0;
      ones      <= '0;
      time_up   <= 1'b0;
    end else begin
      in_r <= bus.time_remain;
      if (start && !busy)
        last_conv <= in_r;
      if (done) begin
        tens    <= tens_c;
        ones    <= ones_c;
        time_up <= (tens_c == 4'd0) && (ones_c == 4'd0);
      end
    end
  end

  assign scan_tc = (scan_cnt == SW'(SCAN_DIV - 1));

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      digit    <= 1'b0;
      scan_on  <= 1'b0;
    end else begin
      scan_cnt <= scan_tc ? '0 : scan_cnt + 1'b1;
      if (scan_tc) begin
        digit   <= ~digit;
        scan_on <= 1'b1;
      end
    end
  end

`ifdef LOW_TIME_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);

  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [6:0]    value;

  assign value = 7'(tens) * 7'd10 + 7'(ones);

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blank = phase && (value != 7'd0) &&
                 (value <= 7'(LOW_THRESH));
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_nx = SEG_BLANK;
    sel_nx = SEL_OFF;
    if (scan_on) begin
      sel_nx = digit ? SEL_TENS : SEL_ONES;
      if (!blank) begin
        if (!digit)
          seg_nx = seg_of(ones);
        else if (tens != 4'd0)
          seg_nx = seg_of(tens);
      end
    end
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= SEG_BLANK;
      sel_r <= SEL_OFF;
    end else begin
      seg_r <= seg_nx;
      sel_r <= sel_nx;
    end
  end

  assign bus.seg     = seg_r;
  assign bus.sel     = sel_r;
  assign bus.time_up = time_up;

endmodule

// File: tb/tb_time_display.sv
// Scoreboard bench for time_display with a fast scan and blink.
// Stimulus queues expected digit codes; a monitor checks each slot.
module tb_time_display;

  typedef struct {
    logic [5:0] v;
    logic [7:0] o;
    logic [7:0] t;
    logic       tu;
    bit         bk;
  } exp_t;

  logic clk50M = 1'b0;
  logic rst_n  = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  exp_t q[$];
  exp_t cur;
  bit   seen_o = 0;
  bit   seen_t = 0;
  bit   blink_on;

  time_display_if bus ();

  time_display #(
    .SCAN_DIV   (4),
    .BLINK_DIV  (16),
    .LOW_THRESH (10)
  ) dut (
    .clk50M (clk50M),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  always #10 clk50M = ~clk50M;

`ifdef LOW_TIME_BLINK_EN
  initial blink_on = 1'b1;
`else
  initial blink_on = 1'b0;
`endif

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] want, input bit bk);
    n_cmp++;
    if (!(got === want || (bk && got === 8'hFF))) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  always @(negedge clk50M) begin
    if (rst_n && q.size() != 0) begin
      cur = q[0];
      if (bus.sel == 2'b10 && !seen_o) begin
        chk($sformatf("v%0d_ones", cur.v), bus.seg, cur.o, cur.bk);
        seen_o = 1;
      end else if (bus.sel == 2'b01 && !seen_t) begin
        chk($sformatf("v%0d_tens", cur.v), bus.seg, cur.t, cur.bk);
        seen_t = 1;
      end
      if (seen_o && seen_t) begin
        chk($sformatf("v%0d_time_up", cur.v),
            {7'd0, bus.time_up}, {7'd0, cur.tu}, 0);
        void'(q.pop_front());
        seen_o = 0;
        seen_t = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk50M);
  endtask

  task automatic set_in(input logic [5:0] v);
    @(negedge clk50M);
    bus.time_remain = v;
  endtask

  task automatic expect_disp(input logic [5:0] v, input logic [7:0] o,
                             input logic [7:0] t, input logic tu,
                             input bit bk);
    exp_t e;
    e.v  = v;
    e.o  = o;
    e.t  = t;
    e.tu = tu;
    e.bk = bk && blink_on;
    q.push_back(e);
    for (int i = 0; i < 60 && q.size() != 0; i++)
      @(posedge clk50M);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL v%0d_timeout: got %0d pending want 0", v, q.size());
      q.delete();
      seen_o = 0;
      seen_t = 0;
    end
  endtask

  initial begin
    bus.time_remain = 6'd60;
    #55;
    chk("rst_seg", bus.seg, 8'hFF, 0);
    chk("rst_sel", {6'd0, bus.sel}, 8'h03, 0);
    chk("rst_time_up", {7'd0, bus.time_up}, 8'h00, 0);
    @(negedge clk50M);
    rst_n = 1'b1;
    @(posedge clk50M);
    #1;
    chk("sel_pre_scan", {6'd0, bus.sel}, 8'h03, 0);
    tick(12);
    expect_disp(6'd60, 8'hC0, 8'h82, 1'b0, 0);

    set_in(6'd59);
    tick(12);
    expect_disp(6'd59, 8'h90, 8'h92, 1'b0, 0);

    set_in(6'd7);
    tick(12);
    expect_disp(6'd7, 8'hF8, 8'hFF, 1'b0, 1);
`ifdef LOW_TIME_BLINK_EN
    begin
      int nb = 0;
      int ns = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk50M);
        if (bus.sel == 2'b10 && bus.seg == 8'hFF) nb++;
        if (bus.sel == 2'b10 && bus.seg == 8'hF8) ns++;
      end
      chk("v7_blank_seen", 8'(nb != 0), 8'h01, 0);
      chk("v7_lit_seen", 8'(ns != 0), 8'h01, 0);
    end
`endif

    set_in(6'd0);
    tick(8);
    #1;
    chk("lat_time_up_early", {7'd0, bus.time_up}, 8'h00, 0);
    @(posedge clk50M);
    #1;
    chk("lat_time_up_9clk", {7'd0, bus.time_up}, 8'h01, 0);
    tick(4);
    for (int i = 0; i < 4; i++)
      expect_disp(6'd0, 8'hC0, 8'hFF, 1'b1, 0);

    set_in(6'd5);
    tick(12);
    expect_disp(6'd5, 8'h92, 8'hFF, 1'b0, 1);

    set_in(6'd45);
    tick(3);
    set_in(6'd44);
    set_in(6'd43);
    tick(15);
    expect_disp(6'd43, 8'hB0, 8'h99, 1'b0, 0);

    set_in(6'd0);
    tick(12);
    expect_disp(6'd0, 8'hC0, 8'hFF, 1'b1, 0);
    set_in(6'd23);
    tick(4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", bus.seg, 8'hFF, 0);
    chk("mid_rst_sel", {6'd0, bus.sel}, 8'h03, 0);
    chk("mid_rst_time_up", {7'd0, bus.time_up}, 8'h00, 0);
    tick(2);
    @(negedge clk50M);
    rst_n = 1'b1;
    tick(14);
    expect_disp(6'd23, 8'hB0, 8'hA4, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
